s32x_fb_fill_engine: RTL and testbench



---
 rtl/s32x_fb_fill_engine.sv | 145 ++++++++++++++
 tb/tb_s32x_fb_fill_engine.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/s32x_fb_fill_engine.sv
// Framebuffer fill/copy engine: writes LEN+1 words of a constant (fill) or moves LEN+1 words SRC->DST (copy).
// Strobes are combinational from state/CE/HOLD; HOLD freezes access states, ABORT and RST drop straight to idle.
module s32x_fb_fill_engine #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int LW        = 8,
  parameter int WAIT      = 2,
  parameter int RD_LAT    = 1,
  parameter int WRAP_BITS = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ce,
  input  logic          i_len_we,
  input  logic [LW-1:0] i_len_di,
  input  logic          i_addr_we,
  input  logic [AW-1:0] i_addr_di,
  input  logic          i_src_we,
  input  logic [AW-1:0] i_src_di,
  input  logic          i_data_we,
  input  logic [DW-1:0] i_data_di,
  input  logic          i_copy_start,
  input  logic          i_abort,
  input  logic          i_hold,
  output logic [AW-1:0] o_mem_a,
  output logic [DW-1:0] o_mem_do,
  output logic [1:0]    o_mem_we,
  output logic          o_mem_rd,
  input  logic [DW-1:0] i_mem_di,
  output logic          o_busy,
  output logic [AW-1:0] o_addr_q,
  output logic [LW-1:0] o_len_q,
  output logic [DW-1:0] o_data_q
);

  localparam int GW = $clog2(WAIT + 2);
  localparam int RW = $clog2(RD_LAT + 1);
  localparam logic [AW:0]   WRAP_ONE  = (AW+1)'(1) << WRAP_BITS;
  localparam logic [AW:0]   WRAP_M1   = WRAP_ONE - 1'b1;
  localparam logic [AW-1:0] WRAP_MASK = WRAP_M1[AW-1:0];

  typedef enum logic [2:0] {
    S_IDLE, S_PEND, S_FILL_WR, S_FILL_GAP, S_CP_RD, S_CP_WAIT, S_CP_WR
  } state_t;

  state_t          r_state, w_next;
  logic [LW-1:0]   r_len, r_cnt;
  logic [AW-1:0]   r_dst, r_src;
  logic [DW-1:0]   r_data, r_buf;
  logic            r_copy;
  logic [GW-1:0]   r_gap;
  logic [RW-1:0]   r_rlat;
  logic            w_go, w_acc_ok, w_we, w_rd, w_gap_last, w_rlat_last;

  // Only the low WRAP_BITS bits count; the upper address bits select the window.
  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] a);
    return (a & ~WRAP_MASK) | ((a + 1'b1) & WRAP_MASK);
  endfunction

  assign w_go        = i_ce & ~i_abort & ~i_rst;
  assign w_acc_ok    = w_go & ~i_hold;
  assign w_we        = w_acc_ok & ((r_state == S_FILL_WR) | (r_state == S_CP_WR));
  assign w_rd        = w_acc_ok & (r_state == S_CP_RD);
  assign w_gap_last  = (r_gap == GW'(WAIT - 1));
  assign w_rlat_last = (r_rlat == RW'(RD_LAT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_abort) begin
      w_next = S_IDLE;
    end else if (i_ce) begin
      case (r_state)
        S_IDLE:     if (i_data_we || i_copy_start) w_next = S_PEND;
        S_PEND:     w_next = r_copy ? S_CP_RD : S_FILL_WR;
        S_FILL_WR:  if (!i_hold) w_next = (r_cnt == '0) ? S_IDLE : ((WAIT > 0) ? S_FILL_GAP : S_FILL_WR);
        S_FILL_GAP: if (w_gap_last) w_next = S_FILL_WR;
        S_CP_RD:    if (!i_hold) w_next = S_CP_WAIT;
        S_CP_WAIT:  if (w_rlat_last) w_next = S_CP_WR;
        S_CP_WR:    if (!i_hold) w_next = (r_cnt == '0) ? S_IDLE : S_CP_RD;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len  <= '0;
      r_cnt  <= '0;
      r_dst  <= '0;
      r_src  <= '0;
      r_data <= '0;
      r_buf  <= '0;
      r_copy <= 1'b0;
      r_gap  <= '0;
      r_rlat <= '0;
    end else if (w_go) begin
      case (r_state)
        S_IDLE: begin
          if (i_len_we)  r_len <= i_len_di;
          if (i_addr_we) r_dst <= i_addr_di;
          if (i_src_we)  r_src <= i_src_di;
          // Fill wins over a simultaneous copy start.
          if (i_data_we) begin
            r_data <= i_data_di;
            r_cnt  <= r_len;
            r_copy <= 1'b0;
          end else if (i_copy_start) begin
            r_cnt  <= r_len;
            r_copy <= 1'b1;
          end
        end
        S_FILL_WR, S_CP_WR: begin
          if (!i_hold) begin
            r_dst <= f_inc(r_dst);
            if (r_state == S_CP_WR) r_src <= f_inc(r_src);
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            r_gap <= '0;
          end
        end
        S_FILL_GAP: r_gap <= r_gap + 1'b1;
        S_CP_RD:    if (!i_hold) r_rlat <= '0;
        S_CP_WAIT: begin
          r_rlat <= r_rlat + 1'b1;
          if (w_rlat_last) r_buf <= i_mem_di;
        end
        default: ;
      endcase
    end
  end

  assign o_mem_a  = (r_state == S_CP_RD) ? r_src : r_dst;
  assign o_mem_do = r_copy ? r_buf : r_data;
  assign o_mem_we = {2{w_we}};
  assign o_mem_rd = w_rd;
  assign o_busy   = (r_state != S_IDLE);
  assign o_addr_q = r_dst;
  assign o_len_q  = o_busy ? r_cnt : r_len;
  assign o_data_q = r_data;

endmodule

// File: tb/tb_s32x_fb_fill_engine.sv
// Bench for s32x_fb_fill_engine: scenario tasks against a word-list model of fill/copy runs.
module tb_s32x_fb_fill_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, ce = 1'b1, len_we = 0, addr_we = 0, src_we = 0, data_we = 0;
  logic        copy_start = 0, abort = 0, hold = 0;
  logic [7:0]  len_di = 0;
  logic [15:0] addr_di = 0, src_di = 0, data_di = 0;
  logic [15:0] mem_a, mem_do, mem_di, addr_q, data_q;
  logic [1:0]  mem_we;
  logic        mem_rd, busy;
  logic [7:0]  len_q;

  s32x_fb_fill_engine dut (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_len_we(len_we), .i_len_di(len_di),
    .i_addr_we(addr_we), .i_addr_di(addr_di), .i_src_we(src_we), .i_src_di(src_di),
    .i_data_we(data_we), .i_data_di(data_di), .i_copy_start(copy_start), .i_abort(abort),
    .i_hold(hold), .o_mem_a(mem_a), .o_mem_do(mem_do), .o_mem_we(mem_we), .o_mem_rd(mem_rd),
    .i_mem_di(mem_di), .o_busy(busy), .o_addr_q(addr_q), .o_len_q(len_q), .o_data_q(data_q)
  );

  logic [15:0] mem  [0:65535];
  logic [15:0] snap [0:65535];
  logic [15:0] rd_pipe = '0;
  assign mem_di = rd_pipe;

  int cyc = 0, n_rd = 0, we_bad = 0;
  logic [15:0] la[$], ld[$];
  int lt[$];
  int n_checks = 0, n_pass = 0;

  // Framebuffer model with one-tick read latency; logs every write edge.
  always @(posedge clk) begin
    if (mem_we == 2'b01 || mem_we == 2'b10) we_bad++;
    if (mem_we != 2'b00) begin
      la.push_back(mem_a); ld.push_back(mem_do); lt.push_back(cyc);
      mem[mem_a] <= mem_do;
    end
    if (mem_rd) begin
      rd_pipe <= mem[mem_a];
      n_rd++;
    end
    cyc <= cyc + 1;
  end

  function automatic logic [15:0] wrap(input logic [15:0] a, input int k);
    logic [7:0] lo;
    lo = a[7:0] + 8'(k);
    return {a[15:8], lo};
  endfunction

  task automatic clr_log();
    la.delete(); ld.delete(); lt.delete(); n_rd = 0;
  endtask

  task automatic load(input logic [7:0] l, input logic [15:0] d, input logic [15:0] s);
    ce = 1; len_we = 1; len_di = l; addr_we = 1; addr_di = d; src_we = 1; src_di = s;
    @(negedge clk);
    len_we = 0; addr_we = 0; src_we = 0;
  endtask

  task automatic start(input bit cp, input logic [15:0] d, output int t0);
    ce = 1;
    if (cp) copy_start = 1; else begin data_we = 1; data_di = d; end
    t0 = cyc;
    @(negedge clk);
    data_we = 0; copy_start = 0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    ok = !busy;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
    n_checks++; if (mem_we !== 2'b00) $display("FAIL reset_we got %b want 00", mem_we); else n_pass++;
    n_checks++; if (mem_rd !== 1'b0) $display("FAIL reset_rd got %0b want 0", mem_rd); else n_pass++;
    n_checks++; if (mem_a !== 16'h0) $display("FAIL reset_mem_a got %h want 0", mem_a); else n_pass++;
    n_checks++; if (mem_do !== 16'h0) $display("FAIL reset_mem_do got %h want 0", mem_do); else n_pass++;
    n_checks++; if ({addr_q, len_q, data_q} !== 40'h0) $display("FAIL reset_readback got %h/%h/%h want 0", addr_q, len_q, data_q); else n_pass++;
  endtask

  task automatic test_fill_wrap();
    int t0; bit ok;
    clr_log();
    load(8'd3, 16'h12FE, 16'h0);
    start(0, 16'hA5A5, t0);
    n_checks++; if (busy !== 1'b1) $display("FAIL fill_busy_rise got %0b want 1", busy); else n_pass++;
    wait_idle(100, ok);
    n_checks++; if (!ok) $display("FAIL fill_timeout busy still high"); else n_pass++;
    n_checks++; if (la.size() != 4) $display("FAIL fill_count got %0d want 4", la.size()); else n_pass++;
    for (int k = 0; k < 4 && k < la.size(); k++) begin
      n_checks++;
      if (la[k] !== wrap(16'h12FE, k) || ld[k] !== 16'hA5A5 || lt[k] != t0 + 2 + 3*k)
        $display("FAIL fill_wr%0d got a=%h d=%h t=%0d want a=%h d=a5a5 t=%0d", k, la[k], ld[k], lt[k] - t0, wrap(16'h12FE, k), 2 + 3*k);
      else n_pass++;
    end
    n_checks++; if (addr_q !== 16'h1202 || len_q !== 8'd3 || data_q !== 16'hA5A5)
      $display("FAIL fill_end got addr=%h len=%h data=%h want 1202/03/a5a5", addr_q, len_q, data_q); else n_pass++;
  endtask

  task automatic test_copy();
    int t0; bit ok;
    clr_log();
    mem[16'h0100] = 16'h1111; mem[16'h0101] = 16'h2222;
    load(8'd1, 16'h0200, 16'h0100);
    start(1, 16'h0, t0);
    wait_idle(100, ok);
    n_checks++; if (!ok || la.size() != 2 || n_rd != 2) $display("FAIL copy_count got ok=%0b wr=%0d rd=%0d want 1/2/2", ok, la.size(), n_rd); else n_pass++;
    for (int k = 0; k < 2 && k < la.size(); k++) begin
      n_checks++;
      if (la[k] !== 16'h0200 + 16'(k) || ld[k] !== (k == 0 ? 16'h1111 : 16'h2222) || lt[k] != t0 + 4 + 3*k)
        $display("FAIL copy_wr%0d got a=%h d=%h t=%0d want t=%0d", k, la[k], ld[k], lt[k] - t0, 4 + 3*k);
      else n_pass++;
    end
    n_checks++; if (addr_q !== 16'h0202) $display("FAIL copy_addr_q got %h want 0202", addr_q); else n_pass++;
  endtask

  task automatic test_hold();
    int t0, bad; bit ok;
    clr_log(); bad = 0;
    load(8'd2, 16'h3000, 16'h0);
    start(0, 16'hBEEF, t0);
    @(negedge clk);
    hold = 1;
    repeat (5) begin
      #1 if (mem_we !== 2'b00) bad++;
      @(negedge clk);
    end
    hold = 0;
    wait_idle(100, ok);
    n_checks++; if (bad != 0) $display("FAIL hold_strobe got %0d strobes want 0", bad); else n_pass++;
    n_checks++; if (!ok || la.size() != 3) $display("FAIL hold_count got %0d want 3", la.size()); else n_pass++;
    for (int k = 0; k < 3 && k < la.size(); k++) begin
      n_checks++;
      if (la[k] !== 16'h3000 + 16'(k) || lt[k] != t0 + 7 + 3*k)
        $display("FAIL hold_wr%0d got a=%h t=%0d want t=%0d", k, la[k], lt[k] - t0, 7 + 3*k);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    int t0, i;
    clr_log();
    load(8'd9, 16'h4000, 16'h0);
    start(0, 16'h1234, t0);
    for (i = 0; i < 50 && la.size() < 2; i++) @(negedge clk);
    n_checks++; if (la.size() != 2) $display("FAIL abort_pre got %0d writes want 2", la.size()); else n_pass++;
    abort = 1;
    @(negedge clk);
    abort = 0;
    n_checks++; if (busy !== 1'b0 || len_q !== 8'd9 || addr_q !== 16'h4002)
      $display("FAIL abort_state got busy=%0b len=%h addr=%h want 0/09/4002", busy, len_q, addr_q); else n_pass++;
    repeat (40) @(negedge clk);
    n_checks++; if (la.size() != 2) $display("FAIL abort_writes got %0d want 2", la.size()); else n_pass++;
    abort = 1; data_we = 1; data_di = 16'h5555;
    @(negedge clk);
    abort = 0; data_we = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || la.size() != 2) $display("FAIL abort_start got busy=%0b wr=%0d want 0/2", busy, la.size()); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int t0, bad; bit ok;
    clr_log(); bad = 0;
    load(8'd3, 16'h5010, 16'h0);
    start(0, 16'h7777, t0);
    addr_we = 1; addr_di = 16'h6000; len_we = 1; len_di = 8'h20;
    data_we = 1; data_di = 16'h0BAD; copy_start = 1; src_we = 1; src_di = 16'h0;
    @(negedge clk);
    addr_we = 0; len_we = 0; data_we = 0; copy_start = 0; src_we = 0;
    wait_idle(100, ok);
    repeat (5) @(negedge clk);
    n_checks++; if (!ok || busy !== 1'b0 || la.size() != 4) $display("FAIL ign_count got busy=%0b wr=%0d want 0/4", busy, la.size()); else n_pass++;
    for (int k = 0; k < la.size(); k++)
      if (la[k] !== 16'h5010 + 16'(k) || ld[k] !== 16'h7777) bad++;
    n_checks++; if (bad != 0) $display("FAIL ign_addrs got %0d bad writes want 0", bad); else n_pass++;
    n_checks++; if (data_q !== 16'h7777 || len_q !== 8'd3 || addr_q !== 16'h5014)
      $display("FAIL ign_regs got data=%h len=%h addr=%h want 7777/03/5014", data_q, len_q, addr_q); else n_pass++;
  endtask

  task automatic test_len_extremes();
    int t0, bad; bit ok;
    clr_log();
    load(8'd0, 16'h7000, 16'h0);
    start(0, 16'h0001, t0);
    wait_idle(50, ok);
    n_checks++; if (!ok || la.size() != 1 || la[0] !== 16'h7000 || addr_q !== 16'h7001)
      $display("FAIL len0 got wr=%0d addr_q=%h want 1/7001", la.size(), addr_q); else n_pass++;
    clr_log(); bad = 0;
    load(8'hFF, 16'h80F0, 16'h0);
    start(0, 16'hC3C3, t0);
    wait_idle(2000, ok);
    n_checks++; if (!ok || la.size() != 256) $display("FAIL len255_count got %0d want 256", la.size()); else n_pass++;
    for (int k = 0; k < la.size(); k++)
      if (la[k] !== wrap(16'h80F0, k) || ld[k] !== 16'hC3C3 || lt[k] != t0 + 2 + 3*k) bad++;
    n_checks++; if (bad != 0) $display("FAIL len255_seq got %0d bad writes want 0", bad); else n_pass++;
    n_checks++; if (addr_q !== 16'h80F0 || we_bad != 0) $display("FAIL len255_end got addr=%h we_split=%0d want 80f0/0", addr_q, we_bad); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int t0, i;
    clr_log();
    load(8'd5, 16'h9000, 16'h0);
    start(0, 16'h4242, t0);
    for (i = 0; i < 50 && la.size() < 1; i++) @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    #1;
    n_checks++; if ({busy, mem_we, mem_rd, mem_a, mem_do, addr_q, len_q, data_q} !== '0)
      $display("FAIL rst_mid got busy=%0b we=%b a=%h do=%h addr=%h len=%h data=%h want 0",
               busy, mem_we, mem_a, mem_do, addr_q, len_q, data_q); else n_pass++;
    rst = 0;
    repeat (20) @(negedge clk);
    n_checks++; if (la.size() != 1) $display("FAIL rst_mid_writes got %0d want 1", la.size()); else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      bit cp; int t0, bad, n; logic [7:0] l; logic [15:0] d, s, v, dat;
      cp = 1'($urandom_range(0, 1)); l = 8'($urandom_range(0, 6));
      d = 16'($urandom); s = 16'($urandom); dat = 16'($urandom);
      clr_log(); bad = 0;
      load(l, d, s);
      for (int a = 0; a < 65536; a++) snap[a] = mem[a];
      start(cp, dat, t0);
      for (n = 0; n < 600 && busy; n++) begin
        ce = ($urandom_range(0, 3) != 0);
        hold = ($urandom_range(0, 2) == 0);
        @(negedge clk);
      end
      ce = 1; hold = 0;
      n_checks++; if (busy !== 1'b0 || la.size() != int'(l) + 1)
        $display("FAIL rand%0d_count got busy=%0b wr=%0d want 0/%0d", it, busy, la.size(), l + 1); else n_pass++;
      for (int k = 0; k < la.size() && k <= int'(l); k++) begin
        v = cp ? snap[wrap(s, k)] : dat;
        snap[wrap(d, k)] = v;
        if (la[k] !== wrap(d, k) || ld[k] !== v) bad++;
      end
      n_checks++; if (bad != 0 || addr_q !== wrap(d, int'(l) + 1))
        $display("FAIL rand%0d_seq got bad=%0d addr_q=%h want 0/%h", it, bad, addr_q, wrap(d, int'(l) + 1)); else n_pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'h5A5A;
    @(negedge clk);
    test_reset();
    test_fill_wrap();
    test_copy();
    test_hold();
    test_abort();
    test_busy_ignore();
    test_len_extremes();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
